// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the three-state FSM encoding and the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell: the additive counterpart of the full subtractor.
// Purely combinational; the serial adder reuses one instance for every bit.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder processes operand bits LSB first, WIDTH edges per add.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow output ovf.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               fa_sum;
    logic               fa_carry;

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                // DONE falls straight back into RUN on start, so back-to-back adds have no gap.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                a_d     = {1'b0, a_q[WIDTH-1:1]};
                b_d     = {1'b0, b_q[WIDTH-1:1]};
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // On the MSB step carry_q is the carry into bit WIDTH-1.
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    cout_d  = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ fa_carry;
`endif
                    state_d = DONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 (directed + random) and WIDTH=2 (exhaustive).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       cin8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0;
    logic [1:0] b2 = '0;
    logic       cin2 = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf2)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 addition; leaves the DUT in DONE when keep is set.
    task automatic op8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                       input bit scramble, input bit keep);
        logic [8:0] exp;
        logic [7:0] prev_sum;
        logic       prev_cout;
        int         lat;
        int         s;
        exp       = 9'(ai) + 9'(bi) + 9'(ci);
        s         = int'($signed(ai)) + int'($signed(bi)) + int'(ci);
        prev_sum  = sum8;
        prev_cout = cout8;
        a8 = ai; b8 = bi; cin8 = ci; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("busy_after_start", busy8, 1);
        lat = 0;
        while (!done8 && lat < 20) begin
            check("sum_held_in_run", {prev_cout, prev_sum}, {cout8, sum8});
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            end
            tick();
            lat++;
        end
        check("latency", lat, 8);
        check("done_busy", busy8, 0);
        check("sum", sum8, exp[7:0]);
        check("cout", cout8, exp[8]);
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", ovf8, (s > 127 || s < -128) ? 1 : 0);
`endif
        $display("op a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d lat=%0d", ai, bi, ci, sum8, cout8, lat);
        if (!keep) begin
            tick();
            check("idle_done", done8, 0);
            check("idle_busy", busy8, 0);
            check("sum_hold_idle", {cout8, sum8}, exp);
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [2:0] exp2;

        // Start coincident with reset must be ignored.
        start8 = 1'b1;
        start2 = 1'b1;
        #1;
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        tick();
        tick();
        check("rst_start_ignored", busy8, 0);
        check("rst_start_ignored2", busy2, 0);
        start8 = 1'b0;
        start2 = 1'b0;
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy8, 0);

        op8(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        op8(8'hFF, 8'h00, 1'b1, 1'b1, 1'b0);

        // Start held high through RUN: exactly one result, no restart.
        a8 = 8'h21; b8 = 8'h43; cin8 = 1'b1; start8 = 1'b1;
        tick();
        lat = 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        check("hold_latency", lat, 8);
        check("hold_sum", sum8, 8'h65);
        start8 = 1'b0;
        tick();
        check("hold_idle_busy", busy8, 0);
        check("hold_idle_done", done8, 0);
        $display("hold-start op sum=%02h lat=%0d", sum8, lat);

        // Back-to-back: start in the DONE cycle enters RUN with no idle gap.
        op8(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);

        // Reset in the 4th RUN cycle aborts the operation.
        a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (3) tick();
        check("pre_rst_busy", busy8, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_sum", sum8, 0);
        check("arst_cout", cout8, 0);
        check("arst_busy", busy8, 0);
        check("arst_done", done8, 0);
`ifdef SERIAL_ADDER_OVF_EN
        check("arst_ovf", ovf8, 0);
`endif
        #1 rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (done8) seen = 1'b1;
        end
        check("no_done_after_rst", seen, 0);
        $display("reset abort: done seen=%0d", seen);
        op8(8'h3C, 8'h5A, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1, ($urandom_range(0, 3) == 0));
        end
        if (done8) tick();

        // Exhaustive WIDTH=2.
        for (int i = 0; i < 32; i++) begin
            logic [4:0] v;
            v = 5'(i);
            a2 = v[4:3]; b2 = v[2:1]; cin2 = v[0];
            exp2 = 3'(a2) + 3'(b2) + 3'(cin2);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            lat = 0;
            while (!done2 && lat < 10) begin
                tick();
                lat++;
            end
            check("w2_latency", lat, 2);
            check("w2_result", {cout2, sum2}, exp2);
`ifdef SERIAL_ADDER_OVF_EN
            begin
                int s2;
                s2 = int'($signed(a2)) + int'($signed(b2)) + int'(cin2);
                check("w2_ovf", ovf2, (s2 > 1 || s2 < -2) ? 1 : 0);
            end
`endif
            $display("w2 a=%0d b=%0d cin=%0d -> cout=%0d sum=%0d", a2, b2, cin2, cout2, sum2);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
